// File: rtl/bsg_hash_bank_pkg.sv
// bsg_hash_bank_pkg: address hash helpers shared by the bank scheduler and reverse-hash users
package bsg_hash_bank_pkg;

   localparam int max_w_lp = 64;

   typedef logic [max_w_lp-1:0] word_t;

   function automatic int lg_banks(input int banks);
      return (banks > 1) ? $clog2(banks) : 0;
   endfunction

   function automatic int index_w(input int width, input int banks);
      return width - lg_banks(banks);
   endfunction

   function automatic word_t bank_of(input word_t addr, input int lg);
      return addr & ((word_t'(1) << lg) - word_t'(1));
   endfunction

   function automatic word_t index_of(input word_t addr, input int lg);
      return addr >> lg;
   endfunction

   // {index, bank}; upper bits come from the zero-extended index, never X
   function automatic word_t reverse_hash(input word_t index, input word_t bank, input int lg);
      return (index << lg) | bank_of(bank, lg);
   endfunction

   function automatic int rr_slot(input int base, input int offset, input int n);
      return (base + offset) % n;
   endfunction

endpackage

// File: rtl/bsg_hash_bank_id_fifo.sv
// bsg_hash_bank_id_fifo: circular FIFO of requester ids for one bank's outstanding requests
module bsg_hash_bank_id_fifo
   import bsg_hash_bank_pkg::*;
#(
   parameter int width_p = 1,
   parameter int els_p   = 4
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               push_i,
   input  logic [width_p-1:0] data_i,
   input  logic               pop_i,
   output logic [width_p-1:0] data_o,
   output logic               full_o,
   output logic               empty_o
);

   localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
   localparam int cnt_w_lp = $clog2(els_p + 1);

   logic [width_p-1:0]  mem [els_p];
   logic [ptr_w_lp-1:0] rd_ptr, wr_ptr;
   logic [cnt_w_lp-1:0] count;
   logic                do_push, do_pop;

   assign full_o  = count == cnt_w_lp'(els_p);
   assign empty_o = count == '0;
   assign data_o  = mem[rd_ptr];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // storage is unreset; only occupied slots are ever observed
   always_ff @(posedge clk_i)
      if (do_push) mem[wr_ptr] <= data_i;

   // pointer and occupancy tracking; a blocked push leaves everything in place
   always_ff @(posedge clk_i or negedge reset_n_i)
      if (!reset_n_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == ptr_w_lp'(els_p - 1)) ? '0 : wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= (rd_ptr == ptr_w_lp'(els_p - 1)) ? '0 : rd_ptr + 1'b1;
         count <= count + cnt_w_lp'(do_push) - cnt_w_lp'(do_pop);
      end

endmodule

// File: rtl/bsg_hash_bank_scheduler.sv
// bsg_hash_bank_scheduler: hashes requests onto banks, round-robin per bank, steers completions home
module bsg_hash_bank_scheduler
   import bsg_hash_bank_pkg::*;
#(
   parameter int num_req_p  = 2,
   parameter int banks_p    = 4,
   parameter int width_p    = 32,
   parameter int fifo_els_p = 4,
   localparam int index_w_lp = index_w(width_p, banks_p)
) (
   input  logic                            clk_i,
   input  logic                            reset_n_i,
   input  logic [num_req_p-1:0]            req_v_i,
   input  logic [num_req_p*width_p-1:0]    req_addr_i,
   output logic [num_req_p-1:0]            req_ready_o,
   output logic [banks_p-1:0]              bank_v_o,
   output logic [banks_p*index_w_lp-1:0]   bank_index_o,
   input  logic [banks_p-1:0]              bank_ready_i,
   input  logic [banks_p-1:0]              bank_resp_v_i,
   input  logic [banks_p*index_w_lp-1:0]   bank_resp_index_i,
   output logic [banks_p-1:0]              bank_resp_ready_o,
   output logic [num_req_p-1:0]            resp_v_o,
   output logic [num_req_p*width_p-1:0]    resp_addr_o,
   input  logic [num_req_p-1:0]            resp_ready_i
);

   localparam int lg_lp     = lg_banks(banks_p);
   localparam int bank_w_lp = (lg_lp > 0) ? lg_lp : 1;
   localparam int id_w_lp   = (num_req_p > 1) ? $clog2(num_req_p) : 1;

   logic [num_req_p-1:0][bank_w_lp-1:0]  req_bank, rr_bank, win_bank;
   logic [num_req_p-1:0][index_w_lp-1:0] req_index;
   logic [num_req_p-1:0][width_p-1:0]    resp_addr;
   logic [banks_p-1:0][index_w_lp-1:0]   bank_index, resp_index;
   logic [banks_p-1:0][id_w_lp-1:0]      rr_req, win_req, head;
   logic [banks_p-1:0]                   fwd_found, push, full, empty;
   logic [num_req_p-1:0]                 ret_found;

   assign bank_index_o = bank_index;
   assign resp_index   = bank_resp_index_i;
   assign resp_addr_o  = resp_addr;

   // split every request address into its bank and in-bank index
   always_comb
      for (int r = 0; r < num_req_p; r++) begin
         req_bank[r]  = bank_w_lp'(bank_of(word_t'(req_addr_i[r*width_p +: width_p]), lg_lp));
         req_index[r] = index_w_lp'(index_of(word_t'(req_addr_i[r*width_p +: width_p]), lg_lp));
      end

   // per bank: first requester at or after the pointer wins; reset forces the issue path idle
   always_comb begin
      fwd_found   = '0;
      win_req     = '0;
      bank_v_o    = '0;
      bank_index  = '0;
      push        = '0;
      req_ready_o = '0;
      for (int b = 0; b < banks_p; b++) begin
         for (int i = 0; i < num_req_p; i++)
            if (!fwd_found[b] && req_v_i[rr_slot(int'(rr_req[b]), i, num_req_p)]
                && req_bank[rr_slot(int'(rr_req[b]), i, num_req_p)] == bank_w_lp'(b)) begin
               fwd_found[b] = 1'b1;
               win_req[b]   = id_w_lp'(rr_slot(int'(rr_req[b]), i, num_req_p));
            end
         bank_v_o[b]   = reset_n_i && fwd_found[b] && !full[b];
         bank_index[b] = req_index[win_req[b]];
         push[b]       = bank_v_o[b] && bank_ready_i[b];
         if (push[b]) req_ready_o[win_req[b]] = 1'b1;
      end
   end

   // per requester: among banks whose oldest outstanding id is ours, the pointer picks one
   always_comb begin
      ret_found         = '0;
      win_bank          = '0;
      resp_v_o          = '0;
      resp_addr         = '0;
      bank_resp_ready_o = '0;
      for (int r = 0; r < num_req_p; r++) begin
         for (int i = 0; i < banks_p; i++)
            if (!ret_found[r] && bank_resp_v_i[rr_slot(int'(rr_bank[r]), i, banks_p)]
                && !empty[rr_slot(int'(rr_bank[r]), i, banks_p)]
                && head[rr_slot(int'(rr_bank[r]), i, banks_p)] == id_w_lp'(r)) begin
               ret_found[r] = 1'b1;
               win_bank[r]  = bank_w_lp'(rr_slot(int'(rr_bank[r]), i, banks_p));
            end
         resp_v_o[r]  = ret_found[r];
         resp_addr[r] = width_p'(reverse_hash(word_t'(resp_index[win_bank[r]]), word_t'(win_bank[r]), lg_lp));
         if (ret_found[r] && resp_ready_i[r]) bank_resp_ready_o[win_bank[r]] = 1'b1;
      end
   end

   // move each pointer just past the winner of a completed handshake
   always_ff @(posedge clk_i or negedge reset_n_i)
      if (!reset_n_i) begin
         rr_req  <= '0;
         rr_bank <= '0;
      end else begin
         for (int b = 0; b < banks_p; b++)
            if (push[b]) rr_req[b] <= id_w_lp'(rr_slot(int'(win_req[b]), 1, num_req_p));
         for (int r = 0; r < num_req_p; r++)
            if (ret_found[r] && resp_ready_i[r]) rr_bank[r] <= bank_w_lp'(rr_slot(int'(win_bank[r]), 1, banks_p));
      end

   for (genvar g = 0; g < banks_p; g++) begin : bank
      bsg_hash_bank_id_fifo #(.width_p(id_w_lp), .els_p(fifo_els_p)) id_fifo (
         .clk_i    (clk_i),
         .reset_n_i(reset_n_i),
         .push_i   (push[g]),
         .data_i   (win_req[g]),
         .pop_i    (bank_resp_ready_o[g]),
         .data_o   (head[g]),
         .full_o   (full[g]),
         .empty_o  (empty[g])
      );

      a_no_orphan: assert property (@(posedge clk_i) disable iff (!reset_n_i) !(bank_resp_v_i[g] && empty[g]))
         else $warning("protocol error: completion on bank %0d with no outstanding id", g);
   end

endmodule

// File: tb/tb_bsg_hash_bank_scheduler.sv
// tb_bsg_hash_bank_scheduler: directed stimulus, queue-based reference model and literal checks
module tb_bsg_hash_bank_scheduler;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]       req_v, req_ready, resp_v, resp_ready;
   logic [1:0][31:0] req_addr, resp_addr;
   logic [3:0]       bank_v, bank_ready, bank_resp_v, bank_resp_ready;
   logic [3:0][29:0] bank_index, bank_resp_index;

   logic [1:0]       s_req_v, s_req_ready, s_resp_v, s_resp_ready;
   logic [1:0][31:0] s_req_addr, s_resp_addr;
   logic             s_bank_v, s_bank_ready, s_bank_resp_v, s_bank_resp_ready;
   logic [31:0]      s_bank_index, s_bank_resp_index;

   int total = 0;
   int passed = 0;
   int q [4][$];
   int rr_req [4] = '{default: 0};
   int rr_bank [2] = '{default: 0};

   bsg_hash_bank_scheduler dut (
      .clk_i(clk), .reset_n_i(reset_n),
      .req_v_i(req_v), .req_addr_i(req_addr), .req_ready_o(req_ready),
      .bank_v_o(bank_v), .bank_index_o(bank_index), .bank_ready_i(bank_ready),
      .bank_resp_v_i(bank_resp_v), .bank_resp_index_i(bank_resp_index), .bank_resp_ready_o(bank_resp_ready),
      .resp_v_o(resp_v), .resp_addr_o(resp_addr), .resp_ready_i(resp_ready)
   );

   bsg_hash_bank_scheduler #(.banks_p(1)) dut1 (
      .clk_i(clk), .reset_n_i(reset_n),
      .req_v_i(s_req_v), .req_addr_i(s_req_addr), .req_ready_o(s_req_ready),
      .bank_v_o(s_bank_v), .bank_index_o(s_bank_index), .bank_ready_i(s_bank_ready),
      .bank_resp_v_i(s_bank_resp_v), .bank_resp_index_i(s_bank_resp_index), .bank_resp_ready_o(s_bank_resp_ready),
      .resp_v_o(s_resp_v), .resp_addr_o(s_resp_addr), .resp_ready_i(s_resp_ready)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // reference model: per-bank id queues, winner = smallest circular distance from the pointer
   always @(negedge clk) begin
      logic [3:0] e_bv, e_brr;
      logic [1:0] e_rr, e_rv;
      int wq [4];
      int wb [2];
      int d;
      e_bv = '0; e_brr = '0; e_rr = '0; e_rv = '0;
      if (!reset_n) begin
         for (int b = 0; b < 4; b++) q[b].delete();
         rr_req = '{default: 0};
         rr_bank = '{default: 0};
      end else begin
         for (int b = 0; b < 4; b++) begin
            wq[b] = -1;
            d = 2;
            for (int r = 0; r < 2; r++)
               if (req_v[r] && int'(req_addr[r][1:0]) == b && (r - rr_req[b] + 2) % 2 < d) begin
                  d = (r - rr_req[b] + 2) % 2;
                  wq[b] = r;
               end
            if (wq[b] >= 0 && q[b].size() < 4) begin
               e_bv[b] = 1'b1;
               chk($sformatf("bank_index[%0d]", b), bank_index[b], req_addr[wq[b]][31:2]);
               if (bank_ready[b]) e_rr[wq[b]] = 1'b1;
            end
         end
         for (int r = 0; r < 2; r++) begin
            wb[r] = -1;
            d = 4;
            for (int b = 0; b < 4; b++)
               if (bank_resp_v[b] && q[b].size() > 0 && q[b][0] == r && (b - rr_bank[r] + 4) % 4 < d) begin
                  d = (b - rr_bank[r] + 4) % 4;
                  wb[r] = b;
               end
            if (wb[r] >= 0) begin
               e_rv[r] = 1'b1;
               chk($sformatf("resp_addr[%0d]", r), resp_addr[r], {bank_resp_index[wb[r]], 2'(wb[r])});
               if (resp_ready[r]) e_brr[wb[r]] = 1'b1;
            end
         end
      end
      chk("bank_v", bank_v, e_bv);
      chk("req_ready", req_ready, e_rr);
      chk("resp_v", resp_v, e_rv);
      chk("bank_resp_ready", bank_resp_ready, e_brr);
      if (reset_n) begin
         for (int b = 0; b < 4; b++)
            if (e_brr[b]) begin
               rr_bank[q[b][0]] = (b + 1) % 4;
               void'(q[b].pop_front());
            end
         for (int b = 0; b < 4; b++)
            if (e_bv[b] && bank_ready[b]) begin
               q[b].push_back(wq[b]);
               rr_req[b] = (wq[b] + 1) % 2;
            end
      end
   end

   initial begin
      req_v = '0; req_addr = '0; bank_ready = '0; bank_resp_v = '0; bank_resp_index = '0; resp_ready = '0;
      s_req_v = '0; s_req_addr = '0; s_bank_ready = 1'b0; s_bank_resp_v = 1'b0; s_bank_resp_index = '0; s_resp_ready = '0;

      // reset holds the issue path idle even with a ready request present
      req_v = 2'b01; req_addr[0] = 32'h106; bank_ready = 4'b0100;
      #2;
      chk("rst_bank_v", bank_v, 4'b0000);
      chk("rst_req_ready", req_ready, 2'b00);
      tick; tick;
      reset_n = 1'b1;
      #2;
      chk("t1_bank_v", bank_v, 4'b0100);
      chk("t1_index", bank_index[2], 30'h41);
      chk("t1_req_ready", req_ready, 2'b01);
      tick;
      req_v = '0; bank_ready = '0; bank_resp_v = 4'b0100; bank_resp_index[2] = 30'h41; resp_ready = 2'b01;
      #2;
      chk("t1_resp_v", resp_v, 2'b01);
      chk("t1_resp_addr", resp_addr[0], 32'h106);
      chk("t1_bank_resp_ready", bank_resp_ready, 4'b0100);
      tick;
      bank_resp_v = '0; resp_ready = '0;

      // contention on bank 1
      req_v = 2'b11; req_addr[0] = 32'h5; req_addr[1] = 32'h9; bank_ready = 4'b0010;
      for (int i = 0; i < 4; i++) begin
         #2 chk($sformatf("cont_grant%0d", i), req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
         tick;
      end
      chk("model_q1_depth", q[1].size(), 4);
      chk("model_q1_order", q[1][0] * 8 + q[1][1] * 4 + q[1][2] * 2 + q[1][3], 5);
      req_v = '0; bank_ready = '0; bank_resp_v = 4'b0010; bank_resp_index[1] = 30'h7; resp_ready = 2'b11;
      for (int i = 0; i < 4; i++) begin
         #2 chk($sformatf("cont_route%0d", i), resp_v, (i % 2 == 0) ? 2'b01 : 2'b10);
         tick;
      end
      bank_resp_v = '0; resp_ready = '0;

      // fill bank 3, then pop while full
      req_v = 2'b01; req_addr[0] = 32'h3; bank_ready = 4'b1000;
      for (int i = 0; i < 4; i++) begin
         #2 chk($sformatf("full_issue%0d", i), req_ready, 2'b01);
         tick;
      end
      #2;
      chk("full_bank_v", bank_v[3], 1'b0);
      chk("full_req_ready", req_ready, 2'b00);
      tick;
      bank_resp_v = 4'b1000; bank_resp_index[3] = 30'h0; resp_ready = 2'b01;
      #2;
      chk("full_pop", bank_resp_ready, 4'b1000);
      chk("full_push_blocked", req_ready, 2'b00);
      tick;
      bank_resp_v = '0;
      #2;
      chk("full_retry_v", bank_v, 4'b1000);
      chk("full_retry_ready", req_ready, 2'b01);
      tick;
      req_v = '0; bank_ready = '0; bank_resp_v = 4'b1000;
      repeat (4) tick;
      bank_resp_v = '0; resp_ready = '0;

      // reset with two outstanding ids on bank 0
      req_v = 2'b01; req_addr[0] = 32'h4; bank_ready = 4'b0001;
      tick;
      req_v = 2'b10; req_addr[1] = 32'h8;
      tick;
      req_v = 2'b01; bank_resp_v = 4'b0001; bank_resp_index[0] = 30'h1; resp_ready = 2'b11;
      #1 reset_n = 1'b0;
      #1;
      chk("mid_rst_bank_v", bank_v, 4'b0000);
      chk("mid_rst_req_ready", req_ready, 2'b00);
      chk("mid_rst_resp_v", resp_v, 2'b00);
      chk("mid_rst_bank_resp_ready", bank_resp_ready, 4'b0000);
      tick;
      reset_n = 1'b1; bank_resp_v = '0; resp_ready = '0;
      req_v = 2'b10; req_addr[1] = 32'hB; bank_ready = 4'b1000;
      #2;
      chk("post_rst_bank_v", bank_v, 4'b1000);
      chk("post_rst_index", bank_index[3], 30'h2);
      chk("post_rst_req_ready", req_ready, 2'b10);
      tick;
      req_v = '0; bank_ready = '0; bank_resp_v = 4'b1000; bank_resp_index[3] = 30'h2; resp_ready = 2'b10;
      #2;
      chk("post_rst_resp_v", resp_v, 2'b10);
      chk("post_rst_resp_addr", resp_addr[1], 32'hB);
      tick;
      bank_resp_v = '0; resp_ready = '0;

      // return collision: banks 0 and 2 both owe requester 1
      req_v = 2'b10; req_addr[1] = 32'h10; bank_ready = 4'b0001;
      tick;
      req_addr[1] = 32'h22; bank_ready = 4'b0100;
      tick;
      req_v = '0; bank_ready = '0; bank_resp_v = 4'b0101;
      bank_resp_index[0] = 30'h4; bank_resp_index[2] = 30'h8; resp_ready = 2'b00;
      #2;
      chk("hold_resp_v", resp_v, 2'b10);
      chk("hold_bank_resp_ready", bank_resp_ready, 4'b0000);
      tick;
      resp_ready = 2'b10;
      #2;
      chk("col_first", bank_resp_ready, 4'b0001);
      chk("col_first_addr", resp_addr[1], 32'h10);
      tick;
      #2;
      chk("col_second", bank_resp_ready, 4'b0100);
      chk("col_second_addr", resp_addr[1], 32'h22);
      tick;
      bank_resp_v = '0; resp_ready = '0;

      // single bank: whole address is the index
      s_req_v = 2'b01; s_req_addr[0] = 32'h8000_0003; s_bank_ready = 1'b1;
      #2;
      chk("s_bank_v", s_bank_v, 1'b1);
      chk("s_index", s_bank_index, 32'h8000_0003);
      chk("s_req_ready", s_req_ready, 2'b01);
      tick;
      s_req_v = '0; s_bank_ready = 1'b0; s_bank_resp_v = 1'b1; s_bank_resp_index = 32'h8000_0003; s_resp_ready = 2'b01;
      #2;
      chk("s_resp_v", s_resp_v, 2'b01);
      chk("s_resp_addr", s_resp_addr[0], 32'h8000_0003);
      chk("s_bank_resp_ready", s_bank_resp_ready, 1'b1);
      tick;
      #2;
      chk("s_orphan_ready", s_bank_resp_ready, 1'b0);
      chk("s_orphan_resp_v", s_resp_v, 2'b00);
      tick;
      s_bank_resp_v = 1'b0; s_resp_ready = '0;
      tick;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
